// File: rtl/kbd_queue.sv
// Keyboard event queue: turns the decoder's held-key level into press events with
// typematic auto-repeat, buffered in a show-ahead FIFO drained one entry per CPU read.
module kbd_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DELAY_CYC = 25_000_000,
    parameter int unsigned RATE_CYC  = 2_500_000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             key_ascii,
    input  logic                   pop,
    input  logic                   ovf_clr,
    output logic [7:0]             rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     last_key_q, last_key_d;
    logic [31:0]    tmr_q, tmr_d;

    logic           push;
    logic [7:0]     push_data;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           do_push, do_pop, drop;

    // Repeat FSM: release beats key change, key change beats the timer.
    always_comb begin
        state_d    = state_q;
        last_key_d = last_key_q;
        tmr_d      = tmr_q;
        push       = 1'b0;
        push_data  = key_ascii;

        unique case (state_q)
            StIdle: begin
                if (key_ascii != 8'h00) begin
                    push       = 1'b1;
                    last_key_d = key_ascii;
                    tmr_d      = 32'd0;
                    state_d    = StDelay;
                end
            end
            StDelay: begin
                if (key_ascii == 8'h00) begin
                    state_d = StIdle;
                end else if (key_ascii != last_key_q) begin
                    push       = 1'b1;
                    last_key_d = key_ascii;
                    tmr_d      = 32'd0;
                end else if (tmr_q == 32'(DELAY_CYC - 1)) begin
                    push      = 1'b1;
                    push_data = last_key_q;
                    tmr_d     = 32'd0;
                    state_d   = StRepeat;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            StRepeat: begin
                if (key_ascii == 8'h00) begin
                    state_d = StIdle;
                end else if (key_ascii != last_key_q) begin
                    push       = 1'b1;
                    last_key_d = key_ascii;
                    tmr_d      = 32'd0;
                    state_d    = StDelay;
                end else if (tmr_q == 32'(RATE_CYC - 1)) begin
                    push      = 1'b1;
                    push_data = last_key_q;
                    tmr_d     = 32'd0;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            last_key_q <= 8'h00;
            tmr_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            last_key_q <= last_key_d;
            tmr_q      <= tmr_d;
        end
    end

    // A pop frees the head slot on the same edge, so a full FIFO still accepts a push.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || pop);
        drop    = push && full && !pop;

        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && do_push) begin
            mem[wptr_q] <= push_data;
        end
    end

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        count    = count_q;
        overflow = overflow_q;
        rd_data  = empty ? 8'h00 : mem[rptr_q];
    end

endmodule

// File: tb/tb_kbd_queue.sv
// Directed bench for kbd_queue with DEPTH=4, DELAY_CYC=8, RATE_CYC=4; expectations are
// hand-computed edge by edge from the first edge that samples each new key.
module tb_kbd_queue;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] key_ascii;
    logic       pop;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       overflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    kbd_queue #(
        .DEPTH    (4),
        .DELAY_CYC(8),
        .RATE_CYC (4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .key_ascii(key_ascii),
        .pop      (pop),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic tap(input logic [7:0] k);
        key_ascii = k;
        step(1);
        key_ascii = 8'h00;
        step(1);
    endtask

    initial begin
        resetn    = 1'b0;
        key_ascii = 8'h00;
        pop       = 1'b0;
        ovf_clr   = 1'b0;
        step(2);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rd", rd_data, 8'h00);
        resetn = 1'b1;
        step(1);

        // Single press
        key_ascii = 8'h41;
        step(3);
        key_ascii = 8'h00;
        step(1);
        check("s1_count", count, 1);
        check("s1_rd", rd_data, 8'h41);
        pop = 1'b1;
        step(1);
        pop = 1'b0;
        check("s1_pop_empty", empty, 1);
        check("s1_pop_rd", rd_data, 8'h00);

        // Auto-repeat: press at edge 0, repeats at 8, 12, 16, 20, 24
        key_ascii = 8'h61;
        step(1);
        check("s2_e0_count", count, 1);
        check("s2_e0_rd", rd_data, 8'h61);
        step(7);
        check("s2_e7_count", count, 1);
        step(1);
        check("s2_e8_count", count, 2);
        step(3);
        check("s2_e11_count", count, 2);
        step(1);
        check("s2_e12_count", count, 3);
        step(3);
        check("s2_e15_full", full, 0);
        step(1);
        check("s2_e16_count", count, 4);
        check("s2_e16_full", full, 1);
        check("s2_e16_ovf", overflow, 0);
        step(3);
        check("s3_e19_ovf", overflow, 0);
        step(1);
        check("s3_e20_ovf", overflow, 1);
        check("s3_e20_count", count, 4);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("s3_clr", overflow, 0);
        step(2);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("s3_clr_vs_set", overflow, 1);
        key_ascii = 8'h00;
        pop       = 1'b1;
        ovf_clr   = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        step(3);
        pop = 1'b0;
        check("s3_drain_empty", empty, 1);
        check("s3_drain_ovf", overflow, 0);

        // Key change restarts the delay timer
        key_ascii = 8'h41;
        step(5);
        key_ascii = 8'h42;
        step(4);
        check("s4_e8_count", count, 2);
        step(4);
        check("s4_e12_count", count, 2);
        step(1);
        check("s4_e13_count", count, 3);
        step(1);
        key_ascii = 8'h00;
        step(5);
        check("s4_rel_count", count, 3);
        check("s4_head0", rd_data, 8'h41);
        pop = 1'b1;
        step(1);
        check("s4_head1", rd_data, 8'h42);
        step(1);
        check("s4_head2", rd_data, 8'h42);
        step(1);
        pop = 1'b0;
        check("s4_empty", empty, 1);

        // Release during DELAY: no repeat
        key_ascii = 8'h43;
        step(3);
        key_ascii = 8'h00;
        step(10);
        check("s4_delay_rel", count, 1);
        check("s4_delay_rd", rd_data, 8'h43);
        pop = 1'b1;
        step(1);
        pop = 1'b0;

        // Simultaneous push and pop while full
        tap(8'h31);
        tap(8'h32);
        tap(8'h33);
        tap(8'h34);
        check("s5_fill", count, 4);
        key_ascii = 8'h35;
        pop       = 1'b1;
        step(1);
        key_ascii = 8'h00;
        check("s5_full_count", count, 4);
        check("s5_full_head", rd_data, 8'h32);
        check("s5_full_ovf", overflow, 0);
        step(1);
        check("s5_head33", rd_data, 8'h33);
        step(1);
        check("s5_head34", rd_data, 8'h34);
        step(1);
        check("s5_tail35", rd_data, 8'h35);
        step(1);
        check("s5_drained", count, 0);

        // Simultaneous push and pop while empty
        key_ascii = 8'h36;
        step(1);
        pop       = 1'b0;
        key_ascii = 8'h00;
        check("s5_empty_count", count, 1);
        check("s5_empty_rd", rd_data, 8'h36);
        pop = 1'b1;
        step(1);
        pop = 1'b0;
        step(1);

        // Reset mid-hold
        tap(8'h71);
        tap(8'h72);
        key_ascii = 8'h5A;
        step(1);
        check("s6_pre_count", count, 3);
        resetn = 1'b0;
        step(1);
        check("s6_rst_count", count, 0);
        check("s6_rst_ovf", overflow, 0);
        check("s6_rst_rd", rd_data, 8'h00);
        resetn = 1'b1;
        step(1);
        check("s6_fresh_count", count, 1);
        check("s6_fresh_rd", rd_data, 8'h5A);
        step(7);
        check("s6_e7_count", count, 1);
        step(1);
        check("s6_e8_count", count, 2);
        key_ascii = 8'h00;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kbd_queue.md
# kbd_queue

Keyboard event queue between the PS/2 keyboard decoder and the CPU's memory-mapped `KBD_ASCII` read path. Converts the decoder's level-style "currently held ASCII" byte into discrete key-press events, and adds typematic auto-repeat. Buffers events in a show-ahead FIFO. Each CPU read of the data register consumes one event, so keystrokes are neither lost nor double-counted between polls.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `DELAY_CYC`, 25_000_000: clk cycles from the initial press to the first repeat (500 ms at 50 MHz).
- `RATE_CYC`, 2_500_000: clk cycles between subsequent repeats (20 Hz at 50 MHz).

Ports:
- `clk`, in, 1: the only clock; `CLK50MHZ` domain.
- `resetn`, in, 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `key_ascii`, in, 8: held-key ASCII from the keyboard decoder; 0 means no key. Already synchronous to `clk`.
- `pop`, in, 1: one-cycle pulse per CPU read of the data register; removes the head entry.
- `ovf_clr`, in, 1: one-cycle pulse; clears `overflow`.
- `rd_data`, out, 8: head entry (show-ahead); 8'h00 when empty.
- `count`, out, $clog2(DEPTH)+1: number of valid entries.
- `empty`, out, 1: `count == 0`.
- `full`, out, 1: `count == DEPTH`.
- `overflow`, out, 1: sticky; an event was dropped because the FIFO was full.

## Operation

Repeat FSM. Registers: `state`, `last_key` (8 bits), `tmr` (32 bits).
- IDLE:
  - `key_ascii != 0`: push `key_ascii`, latch `last_key`, `tmr <= 0`, go to DELAY.
  - Otherwise stay in IDLE.
- DELAY:
  - `key_ascii == 0`: go to IDLE; no push.
  - `key_ascii != 0` and `key_ascii != last_key`: push the new key, latch it, `tmr <= 0`, stay in DELAY. This is a new press.
  - `tmr == DELAY_CYC-1`: push `last_key`, `tmr <= 0`, go to REPEAT.
  - Otherwise `tmr <= tmr+1`.
- REPEAT:
  - Release: go to IDLE.
  - Key change: push the new key, latch it, `tmr <= 0`, go to DELAY.
  - `tmr == RATE_CYC-1`: push `last_key`, `tmr <= 0`.
  - Otherwise `tmr <= tmr+1`.
- Release takes priority over the timer. A key change also takes priority over the timer.

FIFO:
- Circular buffer with read/write pointers of $clog2(DEPTH) bits; pointers wrap modulo DEPTH.
- `count` is a separate register.
- Push and pop on the same edge:
  - Not empty and not full: both succeed; `count` is unchanged.
  - Empty: the pop is ignored and the push succeeds; `count` becomes 1.
  - Full: both succeed; `count` stays at DEPTH; no overflow.
- Push while full with no pop: the byte is dropped and `overflow <= 1`. Pointers and `count` are unchanged.
- `pop` while empty: no effect. Pointers never underflow.
- `ovf_clr` and a new overflow on the same edge: `overflow` ends at 1 (set wins).

Reset (`resetn == 0` at an edge):
- Outputs: `count = 0`, `empty = 1`, `full = 0`, `overflow = 0`, `rd_data = 0`.
- Internal: pointers 0, `state = IDLE`, `last_key = 0`, `tmr = 0`.
- Storage contents need not be cleared.
- Reset in the middle of a hold discards the queue. If the key is still held at the first edge with `resetn == 1`, it is enqueued as a fresh press.

## Timing

- Press latency: if `key_ascii` first becomes nonzero before edge E, the push happens at E. `rd_data`, `count` and `empty` reflect it immediately after E (one-cycle latency).
- For a key held continuously from edge E, pushes occur at:
  - E (the press),
  - E + DELAY_CYC (first repeat),
  - E + DELAY_CYC + k·RATE_CYC for k ≥ 1 (further repeats).
- Pop: after edge E with `pop == 1`, `rd_data` shows the next entry (or 0) immediately after E.
- All outputs are registered or decoded from registers only. There is no combinational path from `key_ascii` or `pop` to any output.
- `pop` and `ovf_clr` are level-sampled each cycle. Holding either high for N cycles acts as N requests.

## Test plan

The bench uses `DEPTH=4`, `DELAY_CYC=8`, `RATE_CYC=4`.

1. **Single press.** `key_ascii = 8'h41` for 3 cycles, then 0.
   - Required: exactly one entry; `rd_data = 8'h41`, `count = 1`.
   - After `pop`: `empty = 1`, `rd_data = 0`.
2. **Auto-repeat.** Hold 8'h61 from edge 0 for 20 cycles, no pops.
   - Required: pushes at edges 0, 8 and 12. At edge 16 the FIFO reaches 4 entries and `full` is asserted.
3. **Overflow.** Continue scenario 2 to edge 20.
   - Required: the push at edge 20 is dropped; `overflow = 1`; `count` stays 4.
   - `ovf_clr` pulse → `overflow = 0`.
   - Then assert `ovf_clr` on the same edge as another dropped push → `overflow` remains 1.
4. **Key change and release.** 8'h41 for 5 cycles, then 8'h42 for 10 cycles, then 0.
   - Required: queue holds 41, 42, 42. The second 42 comes from the repeat 8 cycles after the change; the timer restarted on the change.
   - Release during DELAY produces no further pushes.
5. **Simultaneous push and pop.**
   - With `count = 4`: press a new key while pulsing `pop`. Required: `count` stays 4, the head advances, the new key is at the tail, no overflow.
   - With `count = 0`: push and pop together. Required: `count = 1`.
6. **Reset mid-hold.** Assert `resetn = 0` for 1 cycle while holding 8'h5A with 3 entries queued.
   - Required: `count = 0` and `overflow = 0` after the reset edge.
   - At the next edge 8'h5A is pushed as a fresh press, and the first repeat follows 8 cycles later.
